dm_store_buffer: RTL and testbench

//  Posted-write buffer between the MEM-stage store path and the data memory (DM) write port.

---
 rtl/stbuf_pkg.sv | 15 +
 rtl/stbuf_match.sv | 42 ++++
 rtl/dm_store_buffer.sv | 114 +++++++++++
 tb/tb_dm_store_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stbuf_pkg.sv
// Shared definitions for the data-memory store buffer.
// Default geometry plus the default-width entry layout.
package stbuf_pkg;

  localparam int STBUF_DEPTH = 4;
  localparam int STBUF_AW    = 32;
  localparam int STBUF_DW    = 32;

  typedef struct packed {
    logic [STBUF_AW-1:2] addr;
    logic [STBUF_DW-1:0] data;
    logic [31:0]         pc;
  } stbuf_entry_t;

endpackage

// File: rtl/stbuf_match.sv
// Load-vs-pending-store address compare with youngest-first priority select.
// Purely combinational; the caller supplies the valid mask and write index.
module stbuf_match
  import stbuf_pkg::*;
#(
  parameter int DEPTH = STBUF_DEPTH,
  parameter int TW    = STBUF_AW - 2
) (
  input  logic [TW-1:0]             ld_tag,
  input  logic [DEPTH-1:0][TW-1:0]  tags,
  input  logic [DEPTH-1:0]          valid,
  input  logic [$clog2(DEPTH)-1:0]  wr_idx,
  output logic                      hit,
  output logic [$clog2(DEPTH)-1:0]  hit_idx
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] eq;
  logic [IW-1:0]    idx;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign eq[gi] = valid[gi] && (tags[gi] == ld_tag);
    end
  endgenerate

  // Walk from the oldest slot towards the youngest so the last match written sticks.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_idx - IW'(k);
      if (eq[idx]) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write buffer in front of the data-memory port, owning the DM address mux.
// Define STBUF_FWD_EN to forward load hits from the buffer instead of stalling.
module dm_store_buffer
  import stbuf_pkg::*;
#(
  parameter int DEPTH = STBUF_DEPTH,
  parameter int AW    = STBUF_AW,
  parameter int DW    = STBUF_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid_i,
  input  logic [AW-1:0]            st_addr_i,
  input  logic [DW-1:0]            st_data_i,
  input  logic [31:0]              st_pc_i,
  output logic                     st_ready_o,
  input  logic                     ld_valid_i,
  input  logic [AW-1:0]            ld_addr_i,
  output logic                     ld_fwd_o,
  output logic [DW-1:0]            ld_data_o,
  output logic                     ld_stall_o,
  output logic                     dm_we_o,
  output logic [AW-1:0]            dm_addr_o,
  output logic [DW-1:0]            dm_wdata_o,
  output logic [31:0]              dm_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [AW-1:2] addr;
    logic [DW-1:0] data;
    logic [31:0]   pc;
  } entry_t;

  entry_t        mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0] count;
  logic          empty, full, push, pop;
  entry_t        head;

  logic [DEPTH-1:0][AW-3:0] tags;
  logic [DEPTH-1:0]         valid;
  logic                     hit;
  logic [IW-1:0]            hit_idx;

  assign count = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[IW] != rd_ptr_reg[IW]) &&
                 (wr_ptr_reg[IW-1:0] == rd_ptr_reg[IW-1:0]);
  assign push  = !reset && st_valid_i && !full;
  assign pop   = !reset && !empty && !ld_valid_i;
  assign head  = mem_reg[rd_ptr_reg[IW-1:0]];

  // Entry storage carries no reset: occupancy is defined solely by the pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg[IW-1:0]] <= '{addr: st_addr_i[AW-1:2], data: st_data_i, pc: st_pc_i};
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // A slot is occupied when its distance from the read pointer is below the count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [IW-1:0] offs;
      assign offs      = IW'(gi) - rd_ptr_reg[IW-1:0];
      assign valid[gi] = ({1'b0, offs} < count);
      assign tags[gi]  = mem_reg[gi].addr;
    end
  endgenerate

  stbuf_match #(.DEPTH(DEPTH), .TW(AW-2)) u_match (
    .ld_tag  (ld_addr_i[AW-1:2]),
    .tags    (tags),
    .valid   (valid),
    .wr_idx  (wr_ptr_reg[IW-1:0]),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  assign st_ready_o = !reset && !full;
  assign count_o    = reset ? '0 : count;
  assign dm_we_o    = pop;
  assign dm_addr_o  = reset        ? '0 :
                      ld_valid_i   ? ld_addr_i :
                      empty        ? '0 : {head.addr, 2'b00};
  assign dm_wdata_o = (reset || empty) ? '0 : head.data;
  assign dm_pc_o    = (reset || empty) ? '0 : head.pc;

`ifdef STBUF_FWD_EN
  assign ld_fwd_o   = !reset && ld_valid_i && hit;
  assign ld_data_o  = ld_fwd_o ? mem_reg[hit_idx].data : '0;
  assign ld_stall_o = 1'b0;
`else
  logic unused_hit_idx;
  assign unused_hit_idx = ^hit_idx;
  assign ld_fwd_o   = 1'b0;
  assign ld_data_o  = '0;
  assign ld_stall_o = !reset && ld_valid_i && hit;
`endif

  logic unused_st_low;
  assign unused_st_low = ^st_addr_i[1:0];

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed and mixed-traffic bench for dm_store_buffer with a small DM model.
// Honours STBUF_FWD_EN to select forwarding or stall expectations.
module tb_dm_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, ld_valid;
  logic [31:0] st_addr, st_data, st_pc, ld_addr;
  logic        st_ready, ld_fwd, ld_stall, dm_we;
  logic [31:0] ld_data, dm_addr, dm_wdata, dm_pc;
  logic [2:0]  count;

  always #5 clk = ~clk;

  dm_store_buffer dut (
    .clk(clk), .reset(reset),
    .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data), .st_pc_i(st_pc),
    .st_ready_o(st_ready),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr),
    .ld_fwd_o(ld_fwd), .ld_data_o(ld_data), .ld_stall_o(ld_stall),
    .dm_we_o(dm_we), .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata), .dm_pc_o(dm_pc),
    .count_o(count)
  );

  logic [31:0] dm_mem  [256];
  logic [31:0] ref_mem [256];
  always @(posedge clk) if (dm_we) dm_mem[dm_addr[9:2]] <= dm_wdata;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    st_valid = 1'b1; st_addr = a; st_data = d; st_pc = p;
  endtask

  // Pending-store model for the mixed-traffic phase
  logic [31:0] q_addr [$];
  int          pend_hits;
  logic        do_st, do_ld;
  logic [31:0] a_r, d_r;

  initial begin
    for (int i = 0; i < 256; i++) begin
      dm_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1; ld_valid = 1'b0; ld_addr = '0;
    set_store(32'h3F0, 32'hDEAD_BEEF, 32'h0);
    tick();
    tick();
    check("rst_count", count, 3'd0);
    check("rst_ready", st_ready, 1'b0);
    check("rst_dm_we", dm_we, 1'b0);
    reset = 1'b0; st_valid = 1'b0;
    settle();
    check("post_rst_count", count, 3'd0);
    check("post_rst_ready", st_ready, 1'b1);

    // single store, minimum latency
    set_store(32'h10, 32'hAAAA_5555, 32'h100);
    tick();
    st_valid = 1'b0;
    settle();
    check("t1_count", count, 3'd1);
    check("t1_dm_we", dm_we, 1'b1);
    check("t1_dm_addr", dm_addr, 32'h10);
    check("t1_dm_wdata", dm_wdata, 32'hAAAA_5555);
    check("t1_dm_pc", dm_pc, 32'h100);
    tick();
    check("t1_count_after", count, 3'd0);
    check("t1_dm_we_after", dm_we, 1'b0);
    check("t1_dm_mem", dm_mem[8'h04], 32'hAAAA_5555);
    check("rst_store_dropped", dm_mem[8'hFC], 32'h0);

    // fill with drain blocked by missing loads, then full + drain + store attempt
    ld_valid = 1'b1; ld_addr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      set_store(32'h40 + 32'(4 * k), 32'h11 * 32'(k + 1), 32'h200 + 32'(k));
      tick();
    end
    set_store(32'h50, 32'h55, 32'h204);
    settle();
    check("t2_ready_full", st_ready, 1'b0);
    check("t2_count_full", count, 3'd4);
    check("t2_dm_we_blocked", dm_we, 1'b0);
    check("t2_ld_stall_miss", ld_stall, 1'b0);
    check("t2_dm_addr_load", dm_addr, 32'h80);
    tick();
    check("t2_fifth_held", count, 3'd4);
    ld_valid = 1'b0;
    settle();
    check("t4_dm_we", dm_we, 1'b1);
    check("t4_dm_addr", dm_addr, 32'h40);
    check("t4_dm_wdata", dm_wdata, 32'h11);
    tick();
    check("t4_push_rejected_count", count, 3'd3);
    check("t4_ready_again", st_ready, 1'b1);
    tick();
    check("t4_push_pop_count", count, 3'd3);
    st_valid = 1'b0;
    tick(); tick(); tick();
    check("t4_drained", count, 3'd0);
    for (int k = 0; k < 4; k++)
      check("t4_dm_img", dm_mem[8'h10 + 8'(k)], 32'h11 * 32'(k + 1));
    check("t4_dm_fifth", dm_mem[8'h14], 32'h55);

    // three full fill/drain rounds to exercise pointer wrap
    for (int r = 0; r < 3; r++) begin
      ld_valid = 1'b1; ld_addr = 32'h84;
      for (int k = 0; k < 4; k++) begin
        set_store(32'h100 + 32'(16 * r + 4 * k), 32'hC000_0000 + 32'(16 * r + k), 32'h400 + 32'(16 * r + k));
        tick();
      end
      st_valid = 1'b0;
      settle();
      check("wrap_full", count, 3'd4);
      ld_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        settle();
        check("wrap_dm_we", dm_we, 1'b1);
        check("wrap_dm_addr", dm_addr, 32'h100 + 32'(16 * r + 4 * k));
        check("wrap_dm_wdata", dm_wdata, 32'hC000_0000 + 32'(16 * r + k));
        check("wrap_dm_pc", dm_pc, 32'h400 + 32'(16 * r + k));
        tick();
      end
      check("wrap_empty", count, 3'd0);
    end

    // two stores to one address, then a load of it
    ld_valid = 1'b1; ld_addr = 32'h84;
    set_store(32'h20, 32'h1, 32'h500); tick();
    set_store(32'h20, 32'h2, 32'h504); tick();
    st_valid = 1'b0; ld_addr = 32'h20;
    settle();
`ifdef STBUF_FWD_EN
    check("t3_fwd", ld_fwd, 1'b1);
    check("t3_fwd_data_youngest", ld_data, 32'h2);
    check("t3_no_stall", ld_stall, 1'b0);
    ld_valid = 1'b0;
    tick(); tick();
    check("t3_drained", count, 3'd0);
`else
    check("t3_stall", ld_stall, 1'b1);
    check("t3_fwd_off", ld_fwd, 1'b0);
    check("t3_data_zero", ld_data, 32'h0);
    check("t3_no_drain", dm_we, 1'b0);
    tick();
    check("t3_still_stalled", ld_stall, 1'b1);
    ld_valid = 1'b0;
    settle();
    check("t3_bubble_wdata", dm_wdata, 32'h1);
    tick();
    ld_valid = 1'b1;
    settle();
    check("t3_stall_one_left", ld_stall, 1'b1);
    check("t3_count_one", count, 3'd1);
    ld_valid = 1'b0;
    tick();
    ld_valid = 1'b1;
    settle();
    check("t3_stall_released", ld_stall, 1'b0);
    check("t3_count_zero", count, 3'd0);
    check("t3_dm_addr", dm_addr, 32'h20);
`endif
    check("t3_dm_final", dm_mem[8'h08], 32'h2);

    // reset with three stores pending
    ld_valid = 1'b1; ld_addr = 32'h84;
    for (int k = 0; k < 3; k++) begin
      set_store(32'h200 + 32'(4 * k), 32'h77 + 32'(k), 32'h600);
      tick();
    end
    st_valid = 1'b0; ld_valid = 1'b0; reset = 1'b1;
    settle();
    check("t5_rst_dm_we", dm_we, 1'b0);
    check("t5_rst_count", count, 3'd0);
    tick();
    reset = 1'b0;
    settle();
    check("t5_count", count, 3'd0);
    check("t5_dm_we", dm_we, 1'b0);
    tick(); tick();
    for (int k = 0; k < 3; k++)
      check("t5_dm_untouched", dm_mem[8'h80 + 8'(k)], 32'h0);

    // mixed traffic against a reference memory
    for (int i = 0; i < 256; i++) ref_mem[i] = dm_mem[i];
    q_addr.delete();
    for (int n = 0; n < 300; n++) begin
      do_st = 1'b0; do_ld = 1'b0;
      a_r = 32'h300 + 32'(4 * $urandom_range(0, 7));
      d_r = $urandom;
      case ($urandom_range(0, 2))
        0: do_st = (q_addr.size() < 4);
        1: do_ld = 1'b1;
        default: ;
      endcase
      st_valid = do_st; st_addr = a_r; st_data = d_r; st_pc = 32'(n);
      ld_valid = do_ld; ld_addr = a_r;
      settle();
      check("mix_count", count, 3'(q_addr.size()));
      check("mix_dm_we", dm_we, (q_addr.size() > 0) && !do_ld);
      if (do_st) check("mix_ready", st_ready, 1'b1);
      if (do_ld) begin
        pend_hits = 0;
        foreach (q_addr[j]) if (q_addr[j] == a_r) pend_hits++;
`ifdef STBUF_FWD_EN
        check("mix_fwd", ld_fwd, pend_hits > 0);
        check("mix_stall", ld_stall, 1'b0);
        if (pend_hits > 0) check("mix_fwd_data", ld_data, ref_mem[a_r[9:2]]);
`else
        check("mix_stall", ld_stall, pend_hits > 0);
`endif
        if (pend_hits == 0) check("mix_dm_read", dm_mem[a_r[9:2]], ref_mem[a_r[9:2]]);
      end
      if ((q_addr.size() > 0) && !do_ld) void'(q_addr.pop_front());
      if (do_st) begin
        q_addr.push_back(a_r);
        ref_mem[a_r[9:2]] = d_r;
      end
      tick();
    end
    st_valid = 1'b0; ld_valid = 1'b0;
    for (int n = 0; n < 8 && count != 3'd0; n++) tick();
    check("mix_drained", count, 3'd0);
    for (int k = 0; k < 8; k++)
      check("mix_dm_image", dm_mem[8'hC0 + 8'(k)], ref_mem[8'hC0 + 8'(k)]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
